// File: rtl/product_accumulator.sv
// product_accumulator: sums COUNT consecutive multiplier products into one batch result,
// then holds it behind a valid/ready handshake until the consumer takes it.
module product_accumulator #(
    parameter  int PROD_W = 16,
    parameter  int ACC_W  = 24,
    parameter  int COUNT  = 8,
    localparam int CNT_W  = $clog2(COUNT + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PROD_W-1:0] product,
    input  logic              clear,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  sum,
    output logic              overflow,
    output logic [CNT_W-1:0]  batch_cnt
);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [ACC_W:0]     acc_ext;
    logic               last;

    // One extra bit captures the carry out of the accumulator for the sticky flag.
    assign acc_ext = {1'b0, acc_q} + (ACC_W + 1)'(product);
    assign last    = cnt_q == CNT_W'(COUNT - 1);

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        if (clear) begin
            state_d = ACCUM;
            acc_d   = '0;
            sum_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
        end else if (state_q == ACCUM && in_valid) begin
            acc_d = acc_ext[ACC_W-1:0];
            ovf_d = ovf_q | acc_ext[ACC_W];
            cnt_d = cnt_q + 1'b1;
            if (last) begin
                sum_d   = acc_ext[ACC_W-1:0];
                state_d = HOLD;
            end
        end else if (state_q == HOLD && out_ready) begin
            state_d = ACCUM;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACCUM;
            acc_q   <= '0;
            sum_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end

    // Handshake outputs depend only on registered state, never on in_valid/out_ready.
    assign in_ready  = state_q == ACCUM;
    assign out_valid = state_q == HOLD;
    assign sum       = sum_q;
    assign overflow  = ovf_q;
    assign batch_cnt = cnt_q;

endmodule

// File: tb/tb_product_accumulator.sv
// tb_product_accumulator: directed vector table for the default instance plus
// hand sequences for a narrow-accumulator and a single-product-batch instance.
module tb_product_accumulator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst = 1'b1, a_clr = 1'b0, a_iv = 1'b0, a_ordy = 1'b0;
    logic [15:0] a_prod = '0;
    logic        a_irdy, a_ovld, a_ovf;
    logic [23:0] a_sum;
    logic [3:0]  a_cnt;

    logic        b_rst = 1'b1, b_clr = 1'b0, b_iv = 1'b0, b_ordy = 1'b0;
    logic [15:0] b_prod = '0;
    logic        b_irdy, b_ovld, b_ovf;
    logic [15:0] b_sum;
    logic [3:0]  b_cnt;

    logic        c_rst = 1'b1, c_clr = 1'b0, c_iv = 1'b0, c_ordy = 1'b0;
    logic [15:0] c_prod = '0;
    logic        c_irdy, c_ovld, c_ovf;
    logic [23:0] c_sum;
    logic [0:0]  c_cnt;

    product_accumulator dut_a (
        .clk(clk), .reset(a_rst), .in_valid(a_iv), .in_ready(a_irdy), .product(a_prod),
        .clear(a_clr), .out_valid(a_ovld), .out_ready(a_ordy), .sum(a_sum),
        .overflow(a_ovf), .batch_cnt(a_cnt)
    );

    product_accumulator #(.ACC_W(16)) dut_b (
        .clk(clk), .reset(b_rst), .in_valid(b_iv), .in_ready(b_irdy), .product(b_prod),
        .clear(b_clr), .out_valid(b_ovld), .out_ready(b_ordy), .sum(b_sum),
        .overflow(b_ovf), .batch_cnt(b_cnt)
    );

    product_accumulator #(.COUNT(1)) dut_c (
        .clk(clk), .reset(c_rst), .in_valid(c_iv), .in_ready(c_irdy), .product(c_prod),
        .clear(c_clr), .out_valid(c_ovld), .out_ready(c_ordy), .sum(c_sum),
        .overflow(c_ovf), .batch_cnt(c_cnt)
    );

    typedef struct {
        logic        rst, clr, iv;
        logic [15:0] prod;
        logic        ordy;
        logic        irdy, ovld;
        logic [23:0] sum;
        logic        chks;
        logic        ovf;
        logic [3:0]  cnt;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic v(input logic rst, clr, iv, input logic [15:0] prod, input logic ordy,
                     input logic irdy, ovld, input logic [23:0] sum, input logic chks,
                     input logic ovf, input logic [3:0] cnt);
        vec_t t;
        t.rst = rst; t.clr = clr; t.iv = iv; t.prod = prod; t.ordy = ordy;
        t.irdy = irdy; t.ovld = ovld; t.sum = sum; t.chks = chks; t.ovf = ovf; t.cnt = cnt;
        tbl.push_back(t);
    endtask

    task automatic chk(input string nm, input int idx, input logic [31:0] act, exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0d: got %h expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        n_vec++;
    endtask

    initial begin
        // Default instance: reset, then products 1..8 drained immediately (sum 36).
        v(1,0,0,0,0, 1,0,0,1,0,0);
        for (int k = 1; k <= 8; k++)
            v(0,0,1,16'(k),1, k < 8, k == 8, 24'd36, k == 8, 0, 4'(k));
        v(0,0,0,0,1, 1,0,0,0,0,0);
        // Maximum products, consumer stalls 5 cycles; a product offered during HOLD is ignored.
        for (int k = 1; k <= 8; k++)
            v(0,0,1,16'hFE01,0, k < 8, k == 8, 24'h07F008, k == 8, 0, 4'(k));
        for (int k = 0; k < 5; k++)
            v(0,0,1,16'h1111,0, 0,1,24'h07F008,1,0,8);
        v(0,0,1,16'h1111,1, 1,0,0,0,0,0);
        // Gappy partial batch of 100s, then clear discards it (including a product that cycle).
        for (int k = 0; k < 5; k++)
            v(0,0,k % 2 == 0,16'd100,0, 1,0,0,0,0,4'(k / 2 + 1));
        v(0,1,1,16'd100,0, 1,0,0,1,0,0);
        for (int k = 1; k <= 8; k++)
            v(0,0,1,16'd1,0, k < 8, k == 8, 24'd8, k == 8, 0, 4'(k));
        v(0,0,0,0,0, 0,1,24'd8,1,0,8);
        // Clear drops the held sum even with out_ready high.
        v(0,1,0,0,1, 1,0,0,1,0,0);
        for (int k = 1; k <= 8; k++)
            v(0,0,1,16'(k),0, k < 8, k == 8, 24'd36, k == 8, 0, 4'(k));
        v(1,0,1,16'd5,1, 1,0,0,1,0,0);
        // Reset mid-batch loses the partial batch.
        v(0,0,1,16'd7,0, 1,0,0,0,0,1);
        v(1,0,1,16'd7,0, 1,0,0,1,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            a_rst = tbl[i].rst; a_clr = tbl[i].clr; a_iv = tbl[i].iv;
            a_prod = tbl[i].prod; a_ordy = tbl[i].ordy;
            tick();
            chk("in_ready", i, 32'(a_irdy), 32'(tbl[i].irdy));
            chk("out_valid", i, 32'(a_ovld), 32'(tbl[i].ovld));
            chk("overflow", i, 32'(a_ovf), 32'(tbl[i].ovf));
            chk("batch_cnt", i, 32'(a_cnt), 32'(tbl[i].cnt));
            if (tbl[i].chks) chk("sum", i, 32'(a_sum), 32'(tbl[i].sum));
        end
        a_rst = 1'b0; a_iv = 1'b0;

        // Narrow accumulator: FFFF + 7*2 wraps to 13 with overflow set.
        b_rst = 1'b1;
        tick();
        b_rst = 1'b0; b_iv = 1'b1; b_prod = 16'hFFFF;
        tick();
        b_prod = 16'h0002;
        repeat (7) tick();
        b_iv = 1'b0;
        chk("b_out_valid", 0, 32'(b_ovld), 32'd1);
        chk("b_sum", 0, 32'(b_sum), 32'd13);
        chk("b_overflow", 0, 32'(b_ovf), 32'd1);
        chk("b_batch_cnt", 0, 32'(b_cnt), 32'd8);
        b_ordy = 1'b1;
        tick();
        chk("b_out_valid", 1, 32'(b_ovld), 32'd0);
        chk("b_overflow", 1, 32'(b_ovf), 32'd0);
        chk("b_batch_cnt", 1, 32'(b_cnt), 32'd0);

        // Single-product batches: accept/output alternates every other cycle.
        c_rst = 1'b1;
        tick();
        c_rst = 1'b0; c_iv = 1'b1; c_ordy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [15:0] p;
            p = 16'h1234 + 16'(i * 16'h1111);
            c_prod = p;
            tick();
            chk("c_out_valid", i, 32'(c_ovld), 32'd1);
            chk("c_in_ready", i, 32'(c_irdy), 32'd0);
            chk("c_sum", i, 32'(c_sum), 32'(p));
            chk("c_batch_cnt", i, 32'(c_cnt), 32'd1);
            c_prod = 16'hDEAD;
            tick();
            chk("c_out_valid_drain", i, 32'(c_ovld), 32'd0);
            chk("c_in_ready_drain", i, 32'(c_irdy), 32'd1);
            chk("c_batch_cnt_drain", i, 32'(c_cnt), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream stage of the 8x8 combinational multiplier: consumes its 16-bit product and accumulates COUNT consecutive products into a dot-product sum.
- The upstream operand sequencer drives multiplier operands and asserts in_valid while the product is valid.
- A valid/ready handshake on both sides lets the consumer stall the finished sum without losing data.

Parameters:
- PROD_W, 16, width of the incoming product (matches the 16-bit multiplier output)
- ACC_W, 24, accumulator/sum width; must be >= PROD_W
- COUNT, 8, products per batch; must be >= 1

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  product holds a valid value this cycle
- in_ready  output  1  block accepts a product this cycle
- product  input  PROD_W  unsigned multiplier product
- clear  input  1  synchronous abort; discards the partial or held batch
- out_valid  output  1  sum/overflow hold a completed batch
- out_ready  input  1  consumer takes the sum this cycle
- sum  output  ACC_W  accumulated batch result, modulo 2^ACC_W
- overflow  output  1  sticky flag: a carry out of ACC_W occurred during this batch
- batch_cnt  output  clog2(COUNT+1)  products accepted in the current batch

Behaviour:
- States: ACCUM, HOLD. Reset state is ACCUM.
- Reset values: in_ready=1, out_valid=0, sum=0, overflow=0, batch_cnt=0, internal accumulator=0.
- Priority: reset > clear > normal operation.
- Acceptance: a product is accepted on a rising edge where in_valid && in_ready.
- ACCUM state:
  - in_ready=1, out_valid=0.
  - On accept: acc <= acc + product, zero-extended to ACC_W. Any carry out of bit ACC_W-1 sets the sticky overflow; acc keeps the wrapped value. batch_cnt increments.
  - On the COUNTth accept: sum <= final acc including this product, overflow <= final sticky value, batch_cnt <= COUNT, state -> HOLD.
  - Latency: out_valid rises on the edge that accepts the last product, so it is visible the next cycle.
  - in_valid low: no change; gaps between products are allowed.
- HOLD state:
  - in_ready=0, out_valid=1; sum and overflow are stable.
  - The product input is ignored.
  - On out_valid && out_ready: acc, batch_cnt and the overflow flag clear to 0, state -> ACCUM, out_valid=0 next cycle.
  - No bypass: a product presented in the same cycle as the handoff is not accepted, because in_ready is 0 in HOLD. Throughput is therefore at most COUNT products per COUNT+1 cycles.
- clear:
  - In any state, on the next edge: acc=0, batch_cnt=0, overflow=0, sum=0, out_valid=0, state -> ACCUM.
  - A product accepted in the same cycle as clear is discarded.
  - A held sum is dropped even if out_ready is high that cycle.
- Width rule: with the defaults, the maximum sum is 8*65025 = 520200 < 2^24, so overflow can only assert when ACC_W is reduced.
- Reset mid-batch: identical effect to clear; the partial batch is lost and no output is produced.
- COUNT=1: every accepted product goes straight to HOLD with sum = product.
- in_ready and out_valid are pure functions of state (registered), with no combinational path from in_valid or out_ready.

Test Plan:
- Reset, then feed products 1..8 back-to-back, with out_ready=1 -> out_valid high for one cycle, sum=36, overflow=0, batch_cnt=8; in_ready low for exactly one cycle.
- Feed 8 x 16'hFE01 (255*255) with out_ready=0 for 5 cycles, then 1 -> sum=520200 (24'h07F008) stable for 6 cycles; in_ready=0 throughout HOLD; then returns to ACCUM with batch_cnt=0.
- ACC_W=16 instance: feed 16'hFFFF then 16'h0002, continue to 8 products of value 2 total -> overflow=1, sum=(65535+2*7) mod 65536 = 13.
- Three products of 100 with in_valid toggling on alternate cycles, then assert clear, then 8 products of 1 -> first partial batch discarded; output sum=8, overflow=0.
- Assert reset during HOLD with sum=36 pending -> next cycle out_valid=0, sum=0, in_ready=1, batch_cnt=0.
- COUNT=1 instance: product=16'h1234 accepted, out_ready=1 -> sum=16'h1234 the next cycle, alternating accept/output pattern at one product per 2 cycles.
